mul_hilo_ctrl: RTL and testbench

Sequencing controller for the CPU's pipelined 32x32 Booth/Wallace multiplier. Accepts MULT/MULTU/MTHI/MTLO requests from the EX stage over a valid/ready handshake, registers operands, drives the multiplier, waits out its pipeline latency, and commits the 64-bit product into architectural HI/LO. Owns HI/LO, supports pipeline flush of an in-flight multiply, and exports `busy` so MFHI/MFLO issue logic can interlock.

---
 rtl/mul_hilo_ctrl_pkg.sv | 17 +
 rtl/mul_hilo_ctrl_multipler.sv | 43 ++++
 rtl/mul_hilo_ctrl.sv | 112 +++++++++++
 tb/tb_mul_hilo_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mul_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WB   = 2'b10
    } state_t;

endpackage

// File: rtl/mul_hilo_ctrl_multipler.sv
// Pipelined 32x32 multiplier producing a 64-bit signed or unsigned product.
// Latency: LATENCY cycles from x/y/mul_signed to registered result.
// Backpressure: none; free-running pipeline, caller holds operands stable.
module multipler #(
    parameter int LATENCY = 1
) (
    input  logic        mul_clk,
    input  logic        resetn,
    input  logic        mul_signed,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [63:0] result
);

    logic [63:0] x_ext;
    logic [63:0] y_ext;
    logic [63:0] prod;
    logic [63:0] pipe [LATENCY];

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
    always_comb begin
        x_ext = {{32{mul_signed & x[31]}}, x};
        y_ext = {{32{mul_signed & y[31]}}, y};
        prod  = x_ext * y_ext;
    end

    // Product pipeline; depth sets the result latency.
    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= prod;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign result = pipe[LATENCY-1];

endmodule

// File: rtl/mul_hilo_ctrl.sv
// HI/LO sequencing controller: accepts MULT/MULTU/MTHI/MTLO, runs the multiplier, commits HI/LO.
// Latency: multiply commits LATENCY+1 cycles after accept; MTHI/MTLO visible the next cycle.
// Backpressure: req_ready low while a multiply is in flight; flush blocks acceptance.
module mul_hilo_ctrl
    import mul_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        mul_clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(LATENCY + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   op_a;
    logic [31:0]   op_b;
    logic          op_signed;
    logic [63:0]   result;
    logic          accept;
    logic          is_mul;

    // Handshake decode; a flush in the same cycle vetoes the accept.
    always_comb begin
        req_ready = (state == IDLE) & resetn;
        accept    = req_valid & req_ready & ~flush;
        is_mul    = (req_op == OP_MULT) | (req_op == OP_MULTU);
    end

    // Operand registers hold the multiplier inputs stable for the whole RUN phase.
    multipler #(
        .LATENCY (LATENCY)
    ) u_mul (
        .mul_clk    (mul_clk),
        .resetn     (resetn),
        .mul_signed (op_signed),
        .x          (op_a),
        .y          (op_b),
        .result     (result)
    );

    // Controller FSM, latency counter, operand and HI/LO registers.
    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            op_a      <= req_a;
                            op_b      <= req_b;
                            op_signed <= (req_op == OP_MULT);
                            cnt       <= CW'(LATENCY);
                            state     <= RUN;
                        end else if (req_op == OP_MTHI) begin
                            hi <= req_a;
                        end else begin
                            lo <= req_a;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    // A flush here discards the product without touching HI/LO.
                    if (!flush) begin
                        hi <= result[63:32];
                        lo <= result[31:0];
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status is decoded from state; done is suppressed when the write-back is flushed.
    always_comb begin
        busy = (state != IDLE);
        done = (state == WB) & ~flush & resetn;
    end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl at LATENCY=1 and LATENCY=3.
// Latency: checks exact cycle of done/busy/ready and HI/LO visibility.
// Backpressure: exercises held req_valid, flush in IDLE/RUN/WB and reset mid-multiply.
module tb_mul_hilo_ctrl;

    logic        mul_clk;
    logic        resetn;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;

    logic        ready1, busy1, done1;
    logic [31:0] hi1, lo1;
    logic        ready3, busy3, done3;
    logic [31:0] hi3, lo3;

    logic        rdy, busy, done;
    logic [31:0] hi, lo;
    bit          sel;
    int          lat;
    int          total;
    int          bad;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vt [9];

    mul_hilo_ctrl #(.LATENCY(1)) dut1 (
        .mul_clk   (mul_clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (ready1),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .flush     (flush),
        .hi        (hi1),
        .lo        (lo1),
        .busy      (busy1),
        .done      (done1)
    );

    mul_hilo_ctrl #(.LATENCY(3)) dut3 (
        .mul_clk   (mul_clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (ready3),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .flush     (flush),
        .hi        (hi3),
        .lo        (lo3),
        .busy      (busy3),
        .done      (done3)
    );

    assign rdy  = sel ? ready3 : ready1;
    assign busy = sel ? busy3  : busy1;
    assign done = sel ? done3  : done1;
    assign hi   = sel ? hi3    : hi1;
    assign lo   = sel ? lo3    : lo1;

    initial begin
        mul_clk = 1'b0;
        forever #5 mul_clk = ~mul_clk;
    end

    task automatic cyc();
        @(posedge mul_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lat=%0d got=%h want=%h", nm, lat, act, exp);
        end
    endtask

    // Issue one request from IDLE and follow it to completion with cycle-exact checks.
    task automatic do_op(input vec_t v);
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        #1;
        chk("ready_at_issue", 32'(rdy), 32'd1);
        cyc();
        req_valid = 1'b0;
        #1;
        if (!v.op[1]) begin
            for (int i = 1; i <= lat; i++) begin
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_done", 32'(done), 32'd0);
                chk("run_ready", 32'(rdy), 32'd0);
                cyc();
                #1;
            end
            chk("wb_done", 32'(done), 32'd1);
            chk("wb_busy", 32'(busy), 32'd1);
            cyc();
            #1;
            chk("mul_done_low", 32'(done), 32'd0);
            chk("mul_busy_low", 32'(busy), 32'd0);
            chk("mul_ready", 32'(rdy), 32'd1);
        end else begin
            chk("mt_busy", 32'(busy), 32'd0);
            chk("mt_done", 32'(done), 32'd0);
            chk("mt_ready", 32'(rdy), 32'd1);
        end
        chk("hi", hi, v.eh);
        chk("lo", lo, v.el);
    endtask

    task automatic run_all();
        vec_t v;

        // Reset state
        resetn = 1'b0;
        cyc();
        cyc();
        #1;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(rdy), 32'd0);
        resetn = 1'b1;
        #1;
        chk("post_rst_ready", 32'(rdy), 32'd1);
        cyc();

        // Table-driven multiplies and moves
        for (int i = 0; i < 9; i++) begin
            do_op(vt[i]);
        end

        // MTHI then a MULT issued the very next cycle overwrites HI at write-back
        v = '{op: 2'b10, a: 32'h12345678, b: 32'h0, eh: 32'h12345678, el: 32'h0};
        do_op(v);
        v = '{op: 2'b00, a: 32'd3, b: 32'd4, eh: 32'h0, el: 32'd12};
        do_op(v);

        // req_valid held high: second MULT accepted exactly at T+LATENCY+2
        cyc();
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd2;
        req_b     = 32'd3;
        #1;
        chk("b2b_first_ready", 32'(rdy), 32'd1);
        cyc();
        req_a = 32'd5;
        req_b = 32'd5;
        #1;
        for (int i = 1; i <= lat + 1; i++) begin
            chk("b2b_stall_ready", 32'(rdy), 32'd0);
            chk("b2b_stall_busy", 32'(busy), 32'd1);
            cyc();
            #1;
        end
        chk("b2b_second_ready", 32'(rdy), 32'd1);
        chk("b2b_seen_hi", hi, 32'h0);
        chk("b2b_seen_lo", lo, 32'd6);
        cyc();
        req_valid = 1'b0;
        #1;
        chk("b2b_second_busy", 32'(busy), 32'd1);
        for (int i = 0; i < lat + 1; i++) begin
            cyc();
        end
        #1;
        chk("b2b_hi", hi, 32'h0);
        chk("b2b_lo", lo, 32'd25);

        // Flush during RUN
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'hFFFF0000;
        req_b     = 32'hFFFF0000;
        cyc();
        req_valid = 1'b0;
        flush     = 1'b1;
        #1;
        chk("frun_busy", 32'(busy), 32'd1);
        chk("frun_done", 32'(done), 32'd0);
        cyc();
        flush = 1'b0;
        #1;
        chk("frun_busy_next", 32'(busy), 32'd0);
        chk("frun_ready_next", 32'(rdy), 32'd1);
        for (int i = 0; i < lat + 2; i++) begin
            chk("frun_no_done", 32'(done), 32'd0);
            cyc();
            #1;
        end
        chk("frun_hi", hi, 32'h0);
        chk("frun_lo", lo, 32'd25);

        // Flush during WB
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd1000;
        req_b     = 32'd1000;
        cyc();
        req_valid = 1'b0;
        for (int i = 0; i < lat; i++) begin
            cyc();
        end
        flush = 1'b1;
        #1;
        chk("fwb_busy", 32'(busy), 32'd1);
        chk("fwb_done", 32'(done), 32'd0);
        cyc();
        flush = 1'b0;
        #1;
        chk("fwb_busy_next", 32'(busy), 32'd0);
        chk("fwb_ready_next", 32'(rdy), 32'd1);
        chk("fwb_done_next", 32'(done), 32'd0);
        chk("fwb_hi", hi, 32'h0);
        chk("fwb_lo", lo, 32'd25);

        // Flush in IDLE with a request present: nothing accepted
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_a     = 32'hDEADBEEF;
        flush     = 1'b1;
        cyc();
        req_op = 2'b00;
        req_a  = 32'd7;
        req_b  = 32'd7;
        #1;
        chk("fidle_hi", hi, 32'h0);
        chk("fidle_busy_mt", 32'(busy), 32'd0);
        cyc();
        req_valid = 1'b0;
        flush     = 1'b0;
        #1;
        chk("fidle_busy_mul", 32'(busy), 32'd0);
        chk("fidle_lo", lo, 32'd25);

        // Reset during RUN discards the multiply and clears HI/LO
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'hFFFFFFFF;
        req_b     = 32'd2;
        cyc();
        req_valid = 1'b0;
        resetn    = 1'b0;
        #1;
        chk("rrun_busy_before", 32'(busy), 32'd1);
        cyc();
        #1;
        chk("rrun_hi", hi, 32'h0);
        chk("rrun_lo", lo, 32'h0);
        chk("rrun_busy", 32'(busy), 32'd0);
        chk("rrun_done", 32'(done), 32'd0);
        resetn = 1'b1;
        #1;
        v = '{op: 2'b00, a: 32'd7, b: 32'd6, eh: 32'h0, el: 32'd42};
        do_op(v);
        cyc();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = 32'h0;
        req_b     = 32'h0;
        flush     = 1'b0;

        vt[0] = '{op: 2'b00, a: 32'hFFFFFFFD, b: 32'd5,        eh: 32'hFFFFFFFF, el: 32'hFFFFFFF1};
        vt[1] = '{op: 2'b01, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, eh: 32'hFFFFFFFE, el: 32'h00000001};
        vt[2] = '{op: 2'b00, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, eh: 32'h00000000, el: 32'h00000001};
        vt[3] = '{op: 2'b00, a: 32'h80000000, b: 32'h80000000, eh: 32'h40000000, el: 32'h00000000};
        vt[4] = '{op: 2'b10, a: 32'h12345678, b: 32'h0,        eh: 32'h12345678, el: 32'h00000000};
        vt[5] = '{op: 2'b11, a: 32'h9ABCDEF0, b: 32'h0,        eh: 32'h12345678, el: 32'h9ABCDEF0};
        vt[6] = '{op: 2'b01, a: 32'h00010000, b: 32'h00010000, eh: 32'h00000001, el: 32'h00000000};
        vt[7] = '{op: 2'b00, a: 32'h7FFFFFFF, b: 32'hFFFFFFFF, eh: 32'hFFFFFFFF, el: 32'h80000001};
        vt[8] = '{op: 2'b01, a: 32'h80000000, b: 32'd2,        eh: 32'h00000001, el: 32'h00000000};

        sel = 1'b0;
        lat = 1;
        run_all();

        sel = 1'b1;
        lat = 3;
        run_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
